// File: rtl/pool_window_reader_2.sv
// Port-control mux and sliding-window reader for the layer-2 pool memories.
// Forwards the pool writer's port controls when idle; after pool_done streams KERNELxKERNEL windows.
module pool_window_reader_2 #(
    parameter int unsigned DATA_WIDTH      = 16,
    parameter int unsigned NUM_MULT        = 4,
    parameter int unsigned POOL_ADDR_WIDTH = 8,
    parameter int unsigned FMAP_W          = 12,
    parameter int unsigned FMAP_H          = 12,
    parameter int unsigned KERNEL          = 5,
    parameter int unsigned RD_LAT          = 2,
    parameter int unsigned FIFO_DEPTH      = 4
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             pool_done,
    input  logic [POOL_ADDR_WIDTH-1:0]       address_a_t_out,
    input  logic [POOL_ADDR_WIDTH-1:0]       address_b_t_out,
    input  logic                             rden_a_out,
    input  logic                             rden_b_out,
    input  logic                             wren_a_out,
    input  logic                             wren_b_out,
    output logic [POOL_ADDR_WIDTH-1:0]       address_a_t_use_out,
    output logic [POOL_ADDR_WIDTH-1:0]       address_b_t_use_out,
    output logic                             rden_a_use_out,
    output logic                             rden_b_use_out,
    output logic                             wren_a_use_out,
    output logic                             wren_b_use_out,
    input  logic [DATA_WIDTH*NUM_MULT-1:0]   q_a_all_out,
    input  logic [DATA_WIDTH*NUM_MULT-1:0]   q_b_all_out,
    output logic [DATA_WIDTH*NUM_MULT-1:0]   feat_a_all,
    output logic [DATA_WIDTH*NUM_MULT-1:0]   feat_b_all,
    output logic                             feat_valid,
    output logic                             feat_b_valid,
    output logic                             feat_last,
    input  logic                             feat_ready,
    output logic                             frame_done
);

    localparam int unsigned LaneW = DATA_WIDTH * NUM_MULT;
    localparam int unsigned CntW  = $clog2(FMAP_W + FMAP_H + KERNEL + 2);
    localparam int unsigned OccW  = $clog2(FIFO_DEPTH + 1) + 1;
    localparam int unsigned PtrW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [CntW-1:0]            OxLast  = CntW'(FMAP_W - KERNEL);
    localparam logic [CntW-1:0]            OyLast  = CntW'(FMAP_H - KERNEL);
    localparam logic [CntW-1:0]            KyLast  = CntW'(KERNEL - 1);
    localparam logic [POOL_ADDR_WIDTH-1:0] RowStep = POOL_ADDR_WIDTH'(FMAP_W);
    localparam logic [PtrW-1:0]            PtrLast = PtrW'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {StIdle, StRead, StDrain, StDone} state_e;

    state_e                     state_q, state_d;
    logic                       pool_done_q;
    logic [CntW-1:0]            ox_q, ox_d, oy_q, oy_d, ky_q, ky_d, kx_q, kx_d;
    logic [POOL_ADDR_WIDTH-1:0] win_q, win_d, row_q, row_d, addr_q, addr_d;
    logic [RD_LAT-1:0]          pipe_vld_q, pipe_bv_q, pipe_last_q;
    logic [OccW-1:0]            inflight_q, inflight_d, count_q, count_d;
    logic [PtrW-1:0]            wr_ptr_q, rd_ptr_q;
    logic [LaneW-1:0]           fifo_a_q [FIFO_DEPTH];
    logic [LaneW-1:0]           fifo_b_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]      fifo_bv_q, fifo_last_q;

    logic pd_rise, issue, b_valid, kx_last, win_last, busy, push, pop;

    assign pd_rise  = pool_done & ~pool_done_q;
    assign kx_last  = (kx_q + CntW'(2)) >= CntW'(KERNEL);
    assign b_valid  = (kx_q + CntW'(1)) < CntW'(KERNEL);
    assign win_last = kx_last && (ky_q == KyLast);
    assign busy     = (state_q == StRead) || (state_q == StDrain);
    assign push     = pipe_vld_q[RD_LAT-1];
    assign pop      = (count_q != '0) && feat_ready;
    // Reads in flight reserve FIFO slots so the FIFO can never overflow.
    assign issue    = (state_q == StRead) && ((inflight_q + count_q) < OccW'(FIFO_DEPTH));

    assign inflight_d = inflight_q + OccW'(issue) - OccW'(push);
    assign count_d    = count_q + OccW'(push) - OccW'(pop);

    // Window origin win_q, row start row_q and current address addr_q step without a multiplier.
    always_comb begin
        state_d = state_q;
        ox_d    = ox_q;
        oy_d    = oy_q;
        ky_d    = ky_q;
        kx_d    = kx_q;
        win_d   = win_q;
        row_d   = row_q;
        addr_d  = addr_q;
        unique case (state_q)
            StIdle: begin
                if (pd_rise) begin
                    state_d = StRead;
                    ox_d    = '0;
                    oy_d    = '0;
                    ky_d    = '0;
                    kx_d    = '0;
                    win_d   = '0;
                    row_d   = '0;
                    addr_d  = '0;
                end
            end
            StRead: begin
                if (issue) begin
                    if (!kx_last) begin
                        kx_d   = kx_q + CntW'(2);
                        addr_d = addr_q + POOL_ADDR_WIDTH'(2);
                    end else if (ky_q != KyLast) begin
                        kx_d   = '0;
                        ky_d   = ky_q + CntW'(1);
                        row_d  = row_q + RowStep;
                        addr_d = row_q + RowStep;
                    end else begin
                        kx_d = '0;
                        ky_d = '0;
                        if (ox_q != OxLast) begin
                            ox_d  = ox_q + CntW'(1);
                            win_d = win_q + POOL_ADDR_WIDTH'(1);
                        end else begin
                            // Last column origin plus KERNEL lands on the next row's origin.
                            ox_d  = '0;
                            win_d = win_q + POOL_ADDR_WIDTH'(KERNEL);
                            if (oy_q != OyLast) begin
                                oy_d = oy_q + CntW'(1);
                            end else begin
                                state_d = StDrain;
                            end
                        end
                        row_d  = win_d;
                        addr_d = win_d;
                    end
                end
            end
            StDrain: begin
                if ((inflight_q == '0) && (count_q == '0)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            pool_done_q <= 1'b0;
            ox_q        <= '0;
            oy_q        <= '0;
            ky_q        <= '0;
            kx_q        <= '0;
            win_q       <= '0;
            row_q       <= '0;
            addr_q      <= '0;
            pipe_vld_q  <= '0;
            pipe_bv_q   <= '0;
            pipe_last_q <= '0;
            inflight_q  <= '0;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            state_q        <= state_d;
            pool_done_q    <= pool_done;
            ox_q           <= ox_d;
            oy_q           <= oy_d;
            ky_q           <= ky_d;
            kx_q           <= kx_d;
            win_q          <= win_d;
            row_q          <= row_d;
            addr_q         <= addr_d;
            pipe_vld_q[0]  <= issue;
            pipe_bv_q[0]   <= b_valid;
            pipe_last_q[0] <= win_last;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld_q[i]  <= pipe_vld_q[i-1];
                pipe_bv_q[i]   <= pipe_bv_q[i-1];
                pipe_last_q[i] <= pipe_last_q[i-1];
            end
            inflight_q <= inflight_d;
            count_q    <= count_d;
            if (push) begin
                wr_ptr_q <= (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + PtrW'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_a_q[wr_ptr_q]    <= q_a_all_out;
            fifo_b_q[wr_ptr_q]    <= q_b_all_out;
            fifo_bv_q[wr_ptr_q]   <= pipe_bv_q[RD_LAT-1];
            fifo_last_q[wr_ptr_q] <= pipe_last_q[RD_LAT-1];
        end
    end

    always_comb begin
        address_a_t_use_out = address_a_t_out;
        address_b_t_use_out = address_b_t_out;
        rden_a_use_out      = rden_a_out;
        rden_b_use_out      = rden_b_out;
        wren_a_use_out      = wren_a_out;
        wren_b_use_out      = wren_b_out;
        if (busy) begin
            address_a_t_use_out = addr_q;
            address_b_t_use_out = b_valid ? addr_q + POOL_ADDR_WIDTH'(1) : addr_q;
            rden_a_use_out      = issue;
            rden_b_use_out      = issue & b_valid;
            wren_a_use_out      = 1'b0;
            wren_b_use_out      = 1'b0;
        end
    end

    assign feat_valid   = (count_q != '0);
    assign feat_a_all   = feat_valid ? fifo_a_q[rd_ptr_q] : '0;
    assign feat_b_all   = feat_valid ? fifo_b_q[rd_ptr_q] : '0;
    assign feat_b_valid = feat_valid & fifo_bv_q[rd_ptr_q];
    assign feat_last    = feat_valid & fifo_last_q[rd_ptr_q];
    assign frame_done   = (state_q == StDone);

endmodule

// File: tb/tb_pool_window_reader_2.sv
// Bench for pool_window_reader_2: passthrough vectors, window-order scoreboard and corner sequences.
module tb_pool_window_reader_2;

    localparam int DW = 16;
    localparam int NM = 4;
    localparam int AW = 8;
    localparam int FW = 12;
    localparam int FH = 12;
    localparam int K  = 5;
    localparam int FD = 4;
    localparam int NBEATS = 960;

    logic          clock = 1'b0;
    logic          reset;
    logic          pool_done;
    logic [AW-1:0] address_a_t_out, address_b_t_out;
    logic          rden_a_out, rden_b_out, wren_a_out, wren_b_out;
    logic [AW-1:0] address_a_t_use_out, address_b_t_use_out;
    logic          rden_a_use_out, rden_b_use_out, wren_a_use_out, wren_b_use_out;
    logic [DW*NM-1:0] q_a_all_out, q_b_all_out, feat_a_all, feat_b_all;
    logic          feat_valid, feat_b_valid, feat_last, feat_ready, frame_done;

    pool_window_reader_2 dut (
        .clock               (clock),
        .reset               (reset),
        .pool_done           (pool_done),
        .address_a_t_out     (address_a_t_out),
        .address_b_t_out     (address_b_t_out),
        .rden_a_out          (rden_a_out),
        .rden_b_out          (rden_b_out),
        .wren_a_out          (wren_a_out),
        .wren_b_out          (wren_b_out),
        .address_a_t_use_out (address_a_t_use_out),
        .address_b_t_use_out (address_b_t_use_out),
        .rden_a_use_out      (rden_a_use_out),
        .rden_b_use_out      (rden_b_use_out),
        .wren_a_use_out      (wren_a_use_out),
        .wren_b_use_out      (wren_b_use_out),
        .q_a_all_out         (q_a_all_out),
        .q_b_all_out         (q_b_all_out),
        .feat_a_all          (feat_a_all),
        .feat_b_all          (feat_b_all),
        .feat_valid          (feat_valid),
        .feat_b_valid        (feat_b_valid),
        .feat_last           (feat_last),
        .feat_ready          (feat_ready),
        .frame_done          (frame_done)
    );

    always #5 clock = ~clock;

    // Memory model: two-cycle read latency, lane i holds address + 1000*i.
    function automatic logic [DW*NM-1:0] mem_word(input logic [AW-1:0] a);
        logic [DW*NM-1:0] w;
        for (int i = 0; i < NM; i++) w[i*DW +: DW] = DW'(a) + DW'(1000 * i);
        return w;
    endfunction

    logic [AW-1:0] ra1, ra2, rb1, rb2;
    always_ff @(posedge clock) begin
        ra1 <= address_a_t_use_out;
        ra2 <= ra1;
        rb1 <= address_b_t_use_out;
        rb2 <= rb1;
    end
    assign q_a_all_out = mem_word(ra2);
    assign q_b_all_out = mem_word(rb2);

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, got, exp);
        end
    endtask

    // Reference window order built with plain multiplication.
    int exp_a [NBEATS];
    bit exp_bv [NBEATS];
    bit exp_last [NBEATS];
    int got_a [NBEATS];
    int got_b [NBEATS];
    int got_bv [NBEATS];
    int got_last [NBEATS];

    int nbeats, ndone, stalls, wren_bad, maxocc, timed_out;

    task automatic run_frame(input int mode, input int abort_at, input bit hold, input bit extra);
        int cyc;
        int post;
        bit fin;
        bit done_seen;
        logic [DW*NM-1:0] ea, eb;
        nbeats = 0; ndone = 0; stalls = 0; wren_bad = 0; maxocc = 0; timed_out = 0;
        cyc = 0; post = 0; fin = 1'b0; done_seen = 1'b0;
        @(negedge clock);
        pool_done = 1'b1;
        while (!fin) begin
            @(negedge clock);
            cyc++;
            if (!hold && cyc == 1) pool_done = 1'b0;
            if (hold && cyc == 50) pool_done = 1'b0;
            if (extra && cyc == 300) pool_done = 1'b1;
            if (extra && cyc == 301) pool_done = 1'b0;
            if (mode == 0) feat_ready = 1'b1;
            else if (cyc >= 100 && cyc < 120) feat_ready = 1'b0;
            else feat_ready = 1'($urandom_range(0, 1));
            if (int'(dut.count_q) > maxocc) maxocc = int'(dut.count_q);
            if (frame_done) begin
                ndone++;
                if (!done_seen) post = 6;
                done_seen = 1'b1;
            end else if (!done_seen && (wren_a_use_out || wren_b_use_out)) begin
                wren_bad++;
            end
            if (nbeats > 0 && nbeats < NBEATS && !feat_valid) stalls++;
            if (feat_valid && feat_ready) begin
                if (nbeats < NBEATS) begin
                    ea = mem_word(AW'(exp_a[nbeats]));
                    eb = mem_word(AW'(exp_a[nbeats] + 1));
                    checks++;
                    if (feat_a_all !== ea || feat_b_valid !== exp_bv[nbeats] ||
                        feat_last !== exp_last[nbeats] ||
                        (exp_bv[nbeats] && feat_b_all !== eb)) begin
                        errors++;
                        $display("FAIL beat %0d: got a=%h b=%h bv=%b last=%b, required a=%h b=%h bv=%b last=%b",
                                 nbeats, feat_a_all, feat_b_all, feat_b_valid, feat_last,
                                 ea, eb, exp_bv[nbeats], exp_last[nbeats]);
                    end
                    got_a[nbeats]    = int'(feat_a_all[DW-1:0]);
                    got_b[nbeats]    = int'(feat_b_all[DW-1:0]);
                    got_bv[nbeats]   = int'(feat_b_valid);
                    got_last[nbeats] = int'(feat_last);
                end
                nbeats++;
            end
            if (abort_at >= 0 && nbeats == abort_at) begin
                reset = 1'b1;
                fin = 1'b1;
            end
            if (done_seen) begin
                post--;
                if (post == 0) fin = 1'b1;
            end
            if (cyc >= 20000) begin
                timed_out = 1;
                fin = 1'b1;
            end
        end
        pool_done = 1'b0;
    endtask

    typedef struct {
        logic [AW-1:0] aa, ab;
        logic          ra, rb, wa, wb;
        logic [AW-1:0] exp_aa, exp_ab;
        logic          exp_ra, exp_rb, exp_wa, exp_wb;
    } pt_vec_t;

    typedef struct {
        int idx;
        int a;
        int b;
        int bv;
        int last;
    } spot_t;

    pt_vec_t pt[4];
    spot_t   sp[7];

    initial begin
        int n;
        pt[0] = '{8'h2A, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h2A, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
        pt[1] = '{8'h00, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b1};
        pt[2] = '{8'h81, 8'h7E, 1'b0, 1'b1, 1'b1, 1'b1, 8'h81, 8'h7E, 1'b0, 1'b1, 1'b1, 1'b1};
        pt[3] = '{8'h13, 8'h37, 1'b1, 1'b0, 1'b0, 1'b0, 8'h13, 8'h37, 1'b1, 1'b0, 1'b0, 1'b0};
        sp[0] = '{0, 0, 1, 1, 0};
        sp[1] = '{1, 2, 3, 1, 0};
        sp[2] = '{2, 4, 0, 0, 0};
        sp[3] = '{14, 52, 0, 0, 1};
        sp[4] = '{15, 1, 2, 1, 0};
        sp[5] = '{945, 91, 92, 1, 0};
        sp[6] = '{959, 143, 0, 0, 1};

        n = 0;
        for (int oy = 0; oy <= FH - K; oy++)
            for (int ox = 0; ox <= FW - K; ox++)
                for (int ky = 0; ky < K; ky++)
                    for (int kx = 0; kx < K; kx += 2) begin
                        exp_a[n]    = (oy + ky) * FW + ox + kx;
                        exp_bv[n]   = (kx + 1 < K);
                        exp_last[n] = (ky == K - 1) && (kx + 2 >= K);
                        n++;
                    end

        reset = 1'b1; pool_done = 1'b0; feat_ready = 1'b0;
        address_a_t_out = '0; address_b_t_out = '0;
        rden_a_out = 1'b0; rden_b_out = 1'b0; wren_a_out = 1'b0; wren_b_out = 1'b0;
        repeat (3) @(negedge clock);
        chk("reset_outputs_low", int'({feat_valid, feat_b_valid, feat_last, frame_done}), 0);
        reset = 1'b0;
        @(negedge clock);
        chk("post_reset_outputs_low", int'({feat_valid, feat_b_valid, feat_last, frame_done}), 0);

        for (int i = 0; i < 4; i++) begin
            address_a_t_out = pt[i].aa; address_b_t_out = pt[i].ab;
            rden_a_out = pt[i].ra; rden_b_out = pt[i].rb;
            wren_a_out = pt[i].wa; wren_b_out = pt[i].wb;
            #1;
            chk($sformatf("passthrough_ports_%0d", i),
                int'({address_a_t_use_out, address_b_t_use_out, rden_a_use_out, rden_b_use_out,
                      wren_a_use_out, wren_b_use_out}),
                int'({pt[i].exp_aa, pt[i].exp_ab, pt[i].exp_ra, pt[i].exp_rb,
                      pt[i].exp_wa, pt[i].exp_wb}));
            chk($sformatf("passthrough_feat_quiet_%0d", i),
                int'(feat_a_all[31:0]) | int'(feat_valid) | int'(feat_last), 0);
            @(negedge clock);
        end

        // Writer keeps driving junk while the reader owns the ports.
        address_a_t_out = 8'h5C; address_b_t_out = 8'hA3;
        rden_a_out = 1'b1; rden_b_out = 1'b1; wren_a_out = 1'b1; wren_b_out = 1'b1;

        run_frame(0, -1, 1'b0, 1'b0);
        chk("full_timeout", timed_out, 0);
        chk("full_beats", nbeats, NBEATS);
        chk("full_frame_done", ndone, 1);
        chk("full_wren_forced_low", wren_bad, 0);
        chk("full_rate_stalls", stalls, 0);
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("spot_a_%0d", sp[i].idx), got_a[sp[i].idx], sp[i].a);
            if (sp[i].bv != 0) chk($sformatf("spot_b_%0d", sp[i].idx), got_b[sp[i].idx], sp[i].b);
            chk($sformatf("spot_bv_%0d", sp[i].idx), got_bv[sp[i].idx], sp[i].bv);
            chk($sformatf("spot_last_%0d", sp[i].idx), got_last[sp[i].idx], sp[i].last);
        end

        run_frame(1, -1, 1'b0, 1'b0);
        chk("bp_timeout", timed_out, 0);
        chk("bp_beats", nbeats, NBEATS);
        chk("bp_frame_done", ndone, 1);
        chk("bp_wren_forced_low", wren_bad, 0);
        chk("bp_occupancy_within_depth", int'(maxocc <= FD), 1);

        run_frame(0, -1, 1'b1, 1'b1);
        chk("hold_timeout", timed_out, 0);
        chk("hold_beats", nbeats, NBEATS);
        chk("hold_frame_done", ndone, 1);

        run_frame(0, 400, 1'b0, 1'b0);
        @(negedge clock);
        chk("abort_feat_valid_low", int'(feat_valid), 0);
        chk("abort_passthrough_addr_a", int'(address_a_t_use_out), 8'h5C);
        chk("abort_passthrough_wren", int'({wren_a_use_out, wren_b_use_out}), 3);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        chk("abort_stays_quiet", int'({feat_valid, frame_done}), 0);

        run_frame(0, -1, 1'b0, 1'b0);
        chk("restart_timeout", timed_out, 0);
        chk("restart_beats", nbeats, NBEATS);
        chk("restart_first_a", got_a[0], 0);
        chk("restart_frame_done", ndone, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
